dmem_responder: RTL and testbench

Sequential data-memory responder that serves the load/store requests issued by the execute stage. It holds a 256-word × 32-bit store with active-low byte-lane write enables, using the same lane encoding the execute stage already drives. It replaces the free-running combinational memory access with a req/ready handshake and a registered read response. This prepares the datapath for a multi-cycle or pipelined core.

---
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder
// ----------------------------------------------------------------------------
// Sequential data-memory responder for the execute stage. It serves loads and
// stores through a req/ready handshake. The backing store is a 2**ADDR_W x
// 32-bit array with active-low byte-lane write enables. Load data comes back
// through a registered rdata/rvalid response.
//
// Transaction timing
//   load  accepted at edge N : rvalid/rdata valid after edge N+1,
//                              ready again after edge N+2
//   store accepted at edge N : array written at edge N, wack after edge N,
//                              ready again after edge N+1
//
// Optional feature (compile-time macro DMEM_MMIO_EN)
//   When the macro is defined, word address MMIO_ADDR selects the mmio_out
//   register instead of the array. Stores there update mmio_out byte-lane-wise.
//   Loads there return mmio_out.
//   When the macro is undefined, MMIO_ADDR is ordinary array storage and
//   mmio_out is tied to zero.
//
// Parameters
//   ADDR_W     word-address width, depth = 2**ADDR_W
//   MMIO_ADDR  word address of the output register (macro builds only)
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rstd      in   synchronous active-low reset
//   req       in   request valid, accepted when req && ready at an edge
//   addr      in   word address (taken modulo depth)
//   wdata     in   store data, lane k = wdata[8k+7:8k]
//   wren_n    in   active-low lane write enables, 4'b1111 = load
//   ready     out  responder accepts a request this cycle
//   rdata     out  registered load data, qualified by rvalid
//   rvalid    out  one-cycle pulse, rdata holds the load result
//   wack      out  one-cycle pulse, store committed
//   mmio_out  out  memory-mapped output register
// ============================================================================
module dmem_responder #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  MMIO_ADDR = 8'hFF
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wren_n,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              wack,
    output logic [31:0]       mmio_out
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_ON = 1'b1;
`else
    localparam bit MMIO_ON = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_WACK = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              is_store;
    logic              mmio_hit;

    logic [ADDR_W-1:0] addr_p1;
    logic              mmio_hit_p1;

    // Handshake outputs come from the registered state only, so req has no
    // combinational path to ready, rvalid or wack.
    assign ready    = (state == S_IDLE);
    assign rvalid   = (state == S_RESP);
    assign wack     = (state == S_WACK);

    assign accept   = req && ready;
    assign is_store = ~&wren_n;

    // In builds without the macro, MMIO_ON is zero. The comparison then folds
    // away, and MMIO_ADDR behaves as an ordinary array word.
    assign mmio_hit = MMIO_ON && (addr == MMIO_ADDR);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = is_store ? S_WACK : S_RD;
                end
            end
            S_RD:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            S_WACK:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- stage p1: request fields captured at acceptance ----
    // Only the load path needs the address later. Store data is consumed on
    // the acceptance edge itself, so none of it is held here.
    always_ff @(posedge clk) begin
        if (!rstd) begin
            mmio_hit_p1 <= 1'b0;
        end else if (accept) begin
            mmio_hit_p1 <= mmio_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1 <= addr;
        end
    end

    // Store commit happens on the acceptance edge. Gating with rstd keeps a
    // store presented during reset out of the array. The array itself is
    // never cleared.
    always_ff @(posedge clk) begin
        if (rstd && accept && !mmio_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (!wren_n[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q;

    always_ff @(posedge clk) begin
        if (!rstd) begin
            mmio_q <= 32'h0;
        end else if (accept && mmio_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (!wren_n[k]) begin
                    mmio_q[8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign mmio_out = mmio_q;
`else
    assign mmio_out = 32'h0;
`endif

    // ---- stage p2: registered read response ----
    // rdata is loaded only in RD, so it holds its value through every other
    // state. A store that commits right before a load is already in the
    // array by the time RD samples it.
    always_ff @(posedge clk) begin
        if (!rstd) begin
            rdata <= 32'h0;
        end else if (state == S_RD) begin
            rdata <= mmio_hit_p1 ? mmio_out : mem[addr_p1];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_ON = 1'b1;
`else
    localparam bit MMIO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstd;
    logic        req;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wren_n;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wack;
    logic [31:0] mmio_out;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: word array plus output register.
    logic [31:0] mem_m [256];
    logic [31:0] mmio_m;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .MMIO_ADDR(8'hFF)) dut (
        .clk(clk), .rstd(rstd), .req(req), .addr(addr), .wdata(wdata),
        .wren_n(wren_n), .ready(ready), .rdata(rdata), .rvalid(rvalid),
        .wack(wack), .mmio_out(mmio_out)
    );

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] wn);
        logic [31:0] mask;
        mask = {{8{~wn[3]}}, {8{~wn[2]}}, {8{~wn[1]}}, {8{~wn[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        if (MMIO_ON && a == 8'hFF) return mmio_m;
        return mem_m[a];
    endfunction

    task automatic model_store(input logic [7:0] a, input logic [31:0] d, input logic [3:0] wn);
        if (MMIO_ON && a == 8'hFF) mmio_m = lane_merge(mmio_m, d, wn);
        else                       mem_m[a] = lane_merge(mem_m[a], d, wn);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL wait_ready: ready=%b required 1 within 8 cycles", ready);
        end
    endtask

    task automatic do_store(input logic [7:0] a, input logic [31:0] d, input logic [3:0] wn);
        bit ok;
        wait_ready(ok);
        req = 1'b1; addr = a; wdata = d; wren_n = wn;
        @(posedge clk);
        if (ok) model_store(a, d, wn);
        #1;
        req = 1'b0; wren_n = 4'hF; wdata = $urandom; addr = 8'($urandom);
        vectors++; if (wack !== 1'b1) begin miscompares++; $display("FAIL store_wack a=%h: wack=%b required 1", a, wack); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL store_busy a=%h: ready=%b required 0", a, ready); end
        vectors++; if (mmio_out !== mmio_m) begin miscompares++; $display("FAIL store_mmio a=%h: mmio_out=%h required %h", a, mmio_out, mmio_m); end
        @(posedge clk); #1;
        vectors++; if (wack !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL store_done a=%h: wack=%b ready=%b required 0 1", a, wack, ready); end
    endtask

    task automatic do_load(input logic [7:0] a);
        bit ok;
        logic [31:0] exp;
        exp = model_read(a);
        wait_ready(ok);
        req = 1'b1; addr = a; wren_n = 4'hF; wdata = $urandom;
        @(posedge clk); #1;
        req = 1'b0; addr = 8'($urandom);
        vectors++; if (rvalid !== 1'b0 || ready !== 1'b0) begin miscompares++; $display("FAIL load_rd a=%h: rvalid=%b ready=%b required 0 0", a, rvalid, ready); end
        @(posedge clk); #1;
        vectors++; if (rvalid !== 1'b1) begin miscompares++; $display("FAIL load_rvalid a=%h: rvalid=%b required 1", a, rvalid); end
        vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL load_rdata a=%h: rdata=%h required %h", a, rdata, exp); end
        @(posedge clk); #1;
        vectors++; if (rvalid !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL load_done a=%h: rvalid=%b ready=%b required 0 1", a, rvalid, ready); end
    endtask

    task automatic test_reset();
        rstd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mmio_m = 32'h0;
        vectors++; if (ready    !== 1'b1)  begin miscompares++; $display("FAIL reset_ready: %b required 1", ready); end
        vectors++; if (rvalid   !== 1'b0)  begin miscompares++; $display("FAIL reset_rvalid: %b required 0", rvalid); end
        vectors++; if (wack     !== 1'b0)  begin miscompares++; $display("FAIL reset_wack: %b required 0", wack); end
        vectors++; if (rdata    !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: %h required 0", rdata); end
        vectors++; if (mmio_out !== 32'h0) begin miscompares++; $display("FAIL reset_mmio: %h required 0", mmio_out); end
        rstd = 1'b1;
    endtask

    task automatic test_word_store_load();
        do_store(8'h10, 32'h12345678, 4'b0000);
        do_load(8'h10);
        vectors++; if (rdata !== 32'h12345678) begin miscompares++; $display("FAIL word_hold: rdata=%h required 12345678", rdata); end
    endtask

    task automatic test_halfword();
        do_store(8'h10, 32'hAAAABBBB, 4'b1100);
        do_load(8'h10);
        vectors++; if (rdata !== 32'h1234BBBB) begin miscompares++; $display("FAIL halfword: rdata=%h required 1234bbbb", rdata); end
        do_store(8'h10, 32'hCCCCCC99, 4'b1110);
        do_load(8'h10);
        vectors++; if (rdata !== 32'h1234BB99) begin miscompares++; $display("FAIL byte: rdata=%h required 1234bb99", rdata); end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        logic [31:0] pre;
        pre = mem_m[8'h10];
        wait_ready(ok);
        req = 1'b1; addr = 8'h10; wren_n = 4'hF;
        @(posedge clk); #1;
        // now in RD: present a store that must wait
        req = 1'b1; addr = 8'h10; wdata = 32'h55667788; wren_n = 4'b0000;
        @(posedge clk); #1;
        vectors++; if (rvalid !== 1'b1 || rdata !== pre) begin miscompares++; $display("FAIL busy_load: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, pre); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready: ready=%b required 0", ready); end
        @(posedge clk); #1;
        vectors++; if (ready !== 1'b1 || wack !== 1'b0 || rvalid !== 1'b0) begin miscompares++; $display("FAIL busy_idle: ready=%b wack=%b rvalid=%b required 1 0 0", ready, wack, rvalid); end
        @(posedge clk);
        model_store(8'h10, 32'h55667788, 4'b0000);
        #1;
        req = 1'b0; wren_n = 4'hF;
        vectors++; if (wack !== 1'b1) begin miscompares++; $display("FAIL busy_wack: wack=%b required 1", wack); end
        @(posedge clk); #1;
        do_load(8'h10);
        vectors++; if (rdata !== 32'h55667788) begin miscompares++; $display("FAIL busy_after: rdata=%h required 55667788", rdata); end
    endtask

    task automatic test_mmio();
        do_store(8'hFF, 32'hDEADBEEF, 4'b0000);
        vectors++; if (mmio_out !== (MMIO_ON ? 32'hDEADBEEF : 32'h0)) begin miscompares++; $display("FAIL mmio_reg: mmio_out=%h required %h", mmio_out, MMIO_ON ? 32'hDEADBEEF : 32'h0); end
        do_load(8'hFF);
        vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mmio_load: rdata=%h required deadbeef", rdata); end
        do_store(8'hFF, 32'h01020304, 4'b1110);
        do_load(8'hFF);
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        wait_ready(ok);
        req = 1'b1; addr = 8'h10; wren_n = 4'hF;
        @(posedge clk); #1;
        req = 1'b0; rstd = 1'b0;
        @(posedge clk); #1;
        rstd = 1'b1; mmio_m = 32'h0;
        vectors++; if (rvalid !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL midload_reset: rvalid=%b ready=%b required 0 1", rvalid, ready); end
        vectors++; if (rdata !== 32'h0 || mmio_out !== 32'h0) begin miscompares++; $display("FAIL midload_regs: rdata=%h mmio=%h required 0 0", rdata, mmio_out); end
        @(posedge clk); #1;
        vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL midload_nopulse: rvalid=%b required 0", rvalid); end
        // a store presented during reset is not committed
        rstd = 1'b0; req = 1'b1; addr = 8'h10; wdata = 32'hFFFFFFFF; wren_n = 4'b0000;
        @(posedge clk); #1;
        req = 1'b0; wren_n = 4'hF; rstd = 1'b1;
        vectors++; if (wack !== 1'b0) begin miscompares++; $display("FAIL reset_store_wack: wack=%b required 0", wack); end
        do_load(8'h10);
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [3:0] wn;
        for (int i = 0; i < 256; i++) do_store(8'(i), $urandom, 4'b0000);
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                wn = 4'($urandom_range(0, 14));
                do_store(a, $urandom, wn);
            end else begin
                do_load(a);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstd = 1'b0; req = 1'b0; addr = 8'h0; wdata = 32'h0; wren_n = 4'hF;
        mmio_m = 32'h0;
        test_reset();
        test_word_store_load();
        test_halfword();
        test_busy_ignore();
        test_mmio();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
